// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, write-allocate data cache with combinational lookup.
// The cache drives the shared data bus only on a read hit.
module direct_mapped_cache #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 14,
   parameter int INDEX_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   inout  wire  [DATA_WIDTH-1:0] data,
   input  logic                  we,
   input  logic                  oe,
   output logic                  found
);
   localparam int LINES     = 1 << INDEX_WIDTH;
   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

   logic [INDEX_WIDTH-1:0] idx;
   logic [TAG_WIDTH-1:0]   tag;
   logic [LINES-1:0]       valid_q, valid_d;
   logic [TAG_WIDTH-1:0]   tag_q  [LINES];
   logic [DATA_WIDTH-1:0]  word_q [LINES];
   logic                   hit;

   assign idx = addr[INDEX_WIDTH-1:0];
   assign tag = addr[ADDR_WIDTH-1:INDEX_WIDTH];

   // Reset wins over a simultaneous write, so the write never allocates.
   always_comb begin
      valid_d = valid_q;
      if (rst)     valid_d = '0;
      else if (we) valid_d[idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      valid_q <= valid_d;
   end

   // Tag and word arrays carry no reset; valid bits alone gate every hit.
   always_ff @(posedge clk) begin
      if (!rst && we) begin
         tag_q[idx]  <= tag;
         word_q[idx] <= data;
      end
   end

   assign hit   = valid_q[idx] && (tag_q[idx] == tag);
   assign found = !rst && oe && !we && hit;
   assign data  = found ? word_q[idx] : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_direct_mapped_cache.sv
// Directed self-checking bench for direct_mapped_cache.
// When the cache must not drive, the bench drives a zero probe; any cache drive corrupts it.
module tb_direct_mapped_cache;
   logic        clk;
   logic        rst;
   logic [13:0] addr;
   logic        we;
   logic        oe;
   logic        found;
   logic        tb_drv;
   logic [15:0] tb_dat;
   wire  [15:0] data;
   int          tests;
   int          fails;

   assign data = tb_drv ? tb_dat : 16'hzzzz;

   direct_mapped_cache #(.DATA_WIDTH(16), .ADDR_WIDTH(14), .INDEX_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .we(we), .oe(oe), .found(found)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Store: one clock edge with we=1, oe=1.
   task automatic wr(input logic [13:0] a, input logic [15:0] d);
      addr = a; we = 1'b1; oe = 1'b1; tb_drv = 1'b1; tb_dat = d;
      @(posedge clk); #1;
      we = 1'b0; tb_drv = 1'b0;
   endtask

   // Read: sample mid-cycle, then advance one edge. With probe=1 the bench drives 0 onto the bus.
   task automatic rd(input logic [13:0] a, input logic probe, output logic f, output logic [15:0] d);
      addr = a; we = 1'b0; oe = 1'b1; tb_drv = probe; tb_dat = 16'h0000;
      #2;
      f = found; d = data;
      @(posedge clk); #1;
      tb_drv = 1'b0;
   endtask

   task automatic test_reset();
      logic f; logic [15:0] d;
      rst = 1'b1; addr = 14'h11C; oe = 1'b1; we = 1'b0; tb_drv = 1'b1; tb_dat = 16'h0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++; if (found !== 1'b0) begin fails++; $display("FAIL rst_found_in_reset got %b exp 0", found); end
      rst = 1'b0;
      rd(14'h11C, 1'b1, f, d);
      tests++; if (f !== 1'b0) begin fails++; $display("FAIL reset_read_found got %b exp 0", f); end
      tests++; if (d !== 16'h0000) begin fails++; $display("FAIL reset_read_bus got %h exp undriven", d); end
   endtask

   task automatic test_write_hit();
      logic f; logic [15:0] d;
      addr = 14'h11C; we = 1'b1; oe = 1'b1; tb_drv = 1'b1; tb_dat = 16'h7800;
      #1;
      tests++; if (found !== 1'b0) begin fails++; $display("FAIL write_found_low got %b exp 0", found); end
      @(posedge clk); #1;
      we = 1'b0; tb_drv = 1'b0;
      rd(14'h11C, 1'b0, f, d);
      tests++; if (f !== 1'b1) begin fails++; $display("FAIL hit_found got %b exp 1", f); end
      tests++; if (d !== 16'h7800) begin fails++; $display("FAIL hit_data got %h exp 7800", d); end
   endtask

   task automatic test_conflict();
      logic f; logic [15:0] d;
      rd(14'h12C, 1'b1, f, d);
      tests++; if (f !== 1'b0) begin fails++; $display("FAIL conflict_miss_found got %b exp 0", f); end
      tests++; if (d !== 16'h0000) begin fails++; $display("FAIL conflict_miss_bus got %h exp undriven", d); end
      wr(14'h12C, 16'h0001);
      rd(14'h11C, 1'b1, f, d);
      tests++; if (f !== 1'b0) begin fails++; $display("FAIL evicted_found got %b exp 0", f); end
      rd(14'h12C, 1'b0, f, d);
      tests++; if (f !== 1'b1) begin fails++; $display("FAIL new_owner_found got %b exp 1", f); end
      tests++; if (d !== 16'h0001) begin fails++; $display("FAIL new_owner_data got %h exp 0001", d); end
   endtask

   task automatic test_overwrite();
      logic f; logic [15:0] d;
      wr(14'h11A, 16'h000A);
      wr(14'h11A, 16'h000B);
      rd(14'h11A, 1'b0, f, d);
      tests++; if (f !== 1'b1) begin fails++; $display("FAIL overwrite_found got %b exp 1", f); end
      tests++; if (d !== 16'h000B) begin fails++; $display("FAIL overwrite_data got %h exp 000b", d); end
   endtask

   task automatic test_fill_reset();
      logic f; logic [15:0] d;
      for (int i = 0; i < 16; i++) wr(14'h100 + 14'(i), 16'h0100 + 16'(i));
      rd(14'h107, 1'b0, f, d);
      tests++; if (f !== 1'b1 || d !== 16'h0107) begin fails++; $display("FAIL fill_hit got %b/%h exp 1/0107", f, d); end
      rd(14'h10F, 1'b0, f, d);
      tests++; if (f !== 1'b1 || d !== 16'h010F) begin fails++; $display("FAIL fill_hit_last got %b/%h exp 1/010f", f, d); end
      rst = 1'b1; addr = 14'h105; oe = 1'b1; tb_drv = 1'b1; tb_dat = 16'h0000;
      #1;
      tests++; if (found !== 1'b0) begin fails++; $display("FAIL rst_masks_hit got %b exp 0", found); end
      @(posedge clk); #1;
      rst = 1'b0; tb_drv = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd(14'h100 + 14'(i), 1'b1, f, d);
         tests++;
         if (f !== 1'b0 || d !== 16'h0000) begin
            fails++; $display("FAIL fill_after_rst addr=%h got %b/%h exp 0/undriven", 14'h100 + 14'(i), f, d);
         end
      end
   endtask

   task automatic test_rst_we_oe();
      logic f; logic [15:0] d;
      wr(14'h120, 16'h5555);
      rst = 1'b1; we = 1'b1; oe = 1'b1; addr = 14'h120; tb_drv = 1'b1; tb_dat = 16'h1234;
      @(posedge clk); #1;
      rst = 1'b0; we = 1'b0; tb_drv = 1'b0;
      rd(14'h120, 1'b1, f, d);
      tests++; if (f !== 1'b0) begin fails++; $display("FAIL rst_beats_write got %b exp 0", f); end
      wr(14'h130, 16'h00C3);
      addr = 14'h130; we = 1'b0; oe = 1'b0; tb_drv = 1'b1; tb_dat = 16'h0000;
      #2;
      tests++; if (found !== 1'b0) begin fails++; $display("FAIL oe_low_found got %b exp 0", found); end
      tests++; if (data !== 16'h0000) begin fails++; $display("FAIL oe_low_bus got %h exp undriven", data); end
      @(posedge clk); #1;
      tb_drv = 1'b0;
      rd(14'h130, 1'b0, f, d);
      tests++; if (f !== 1'b1 || d !== 16'h00C3) begin fails++; $display("FAIL oe_high_hit got %b/%h exp 1/00c3", f, d); end
   endtask

   task automatic test_back_to_back();
      logic f; logic [15:0] d;
      wr(14'h3FF5, 16'hBEEF);
      wr(14'h0005, 16'h0F0F);
      rd(14'h3FF5, 1'b1, f, d);
      tests++; if (f !== 1'b0) begin fails++; $display("FAIL b2b_evict got %b exp 0", f); end
      rd(14'h0005, 1'b0, f, d);
      tests++; if (f !== 1'b1 || d !== 16'h0F0F) begin fails++; $display("FAIL b2b_hit got %b/%h exp 1/0f0f", f, d); end
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; addr = '0; we = 1'b0; oe = 1'b0; tb_drv = 1'b0; tb_dat = '0;
      test_reset();
      test_write_hit();
      test_conflict();
      test_overwrite();
      test_fill_reset();
      test_rst_we_oe();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
